// File: rtl/pipe_stall_ctrl.sv
// Stall/flush arbiter for the 5-stage core: freezes, bubbles, flushes,
// SWP load/store sequencing, saturating event counters, memory timeout.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   hazard_detected   RAW hazard on ID instruction (ignored for SWP)
//   id_valid          ID holds a real instruction
//   is_swp            ID instruction is SWP
//   branch_taken      taken branch resolved in EXE
//   mem_access        MEM stage holds a load/store
//   mem_ready         SRAM completes the access this cycle
//   freeze_pc         hold PC
//   freeze_if_id      hold IF/ID
//   bubble_id_exe     load NOP into ID/EXE
//   flush_if_id       clear IF/ID to a bubble
//   freeze_exe_mem    hold ID/EXE, EXE/MEM, MEM/WB
//   swp_phase         0 none, 1 SWP load uop, 2 SWP store uop
//   stall_count       saturating count of freeze_pc cycles
//   flush_count       saturating count of flush_if_id cycles
//   mem_timeout       sticky: memory wait reached MEM_TIMEOUT cycles
module pipe_stall_ctrl #(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             hazard_detected,
   input  logic             id_valid,
   input  logic             is_swp,
   input  logic             branch_taken,
   input  logic             mem_access,
   input  logic             mem_ready,
   output logic             freeze_pc,
   output logic             freeze_if_id,
   output logic             bubble_id_exe,
   output logic             flush_if_id,
   output logic             freeze_exe_mem,
   output logic [1:0]       swp_phase,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count,
   output logic             mem_timeout
);

   localparam int MW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [MW-1:0] WAIT_LAST = MW'(MEM_TIMEOUT - 1);

   typedef enum logic {
      RUN,
      SWP_ST
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic [MW-1:0]   mem_wait_cnt;
   logic            mb;
   logic            swp_pend;

   assign mb       = mem_access & ~mem_ready;
   assign swp_pend = (state == RUN) & id_valid & is_swp;

   always_comb begin
      freeze_pc      = 1'b0;
      freeze_if_id   = 1'b0;
      bubble_id_exe  = 1'b0;
      flush_if_id    = 1'b0;
      freeze_exe_mem = 1'b0;
      swp_phase      = 2'd0;
      state_nx       = RUN;
      priority case (1'b1)
         mb: begin
            // Whole pipe holds; the SWP micro-op in flight keeps its phase.
            freeze_pc      = 1'b1;
            freeze_if_id   = 1'b1;
            freeze_exe_mem = 1'b1;
            if (state == SWP_ST)
               swp_phase = 2'd2;
            else if (swp_pend)
               swp_phase = 2'd1;
            state_nx = state;
         end
         branch_taken: begin
            // Squashes any SWP in ID or mid-sequence.
            flush_if_id   = 1'b1;
            bubble_id_exe = 1'b1;
            state_nx      = RUN;
         end
         (state == SWP_ST): begin
            swp_phase = 2'd2;
            state_nx  = RUN;
         end
         swp_pend: begin
            // Hold SWP in ID one more cycle to issue the store uop.
            swp_phase    = 2'd1;
            freeze_pc    = 1'b1;
            freeze_if_id = 1'b1;
            state_nx     = SWP_ST;
         end
         (id_valid & hazard_detected): begin
            freeze_pc     = 1'b1;
            freeze_if_id  = 1'b1;
            bubble_id_exe = 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= RUN;
         stall_count  <= '0;
         flush_count  <= '0;
         mem_wait_cnt <= '0;
         mem_timeout  <= 1'b0;
      end else begin
         state <= state_nx;
         if (freeze_pc && stall_count != '1)
            stall_count <= stall_count + 1'b1;
         if (flush_if_id && flush_count != '1)
            flush_count <= flush_count + 1'b1;
         if (mb) begin
            // Parks at the last value; the flag is sticky from then on.
            if (mem_wait_cnt == WAIT_LAST)
               mem_timeout <= 1'b1;
            else
               mem_wait_cnt <= mem_wait_cnt + 1'b1;
         end else begin
            mem_wait_cnt <= '0;
         end
      end
   end

endmodule
